bsg_count_match_event: RTL
==========================

BSG_COUNT_MATCH_EVENT -- requirements
Module: bsg_count_match_event

Interface
- REQ-001: Parameter width_p, default 6: width of the observed count and of the threshold.
- REQ-002: Parameter max_val_p, default 50: largest legal threshold value.
- REQ-003: Parameter ts_width_p, default 8: width of the event timestamp.
- REQ-004: Port clk_i, input, 1: the single clock; all state updates on its rising edge.
- REQ-005: Port reset_i, input, 1: synchronous, active-high reset.
- REQ-006: Port count_i, input, width_p: count from the upstream settable counter, registered at its source.
- REQ-007: Port thresh_set_i, input, 1: write strobe for the threshold register.
- REQ-008: Port thresh_i, input, width_p: new threshold value.
- REQ-009: Port v_o, output, 1: event record available at the buffer head.
- REQ-010: Port ts_o, output, ts_width_p: timestamp of the head event record.
- REQ-011: Port yumi_i, input, 1: consumer takes the head record this cycle.
- REQ-012: Port dropped_o, output, 4: saturating count of dropped events.

Function
- REQ-013: thresh_r SHALL load thresh_i on a cycle with thresh_set_i=1 and thresh_i<=max_val_p, effective the next cycle.
- REQ-014: A write with thresh_i>max_val_p SHALL be ignored, leaving thresh_r unchanged.
- REQ-015: match is (count_i==thresh_r); match_prev is match registered every cycle.
- REQ-016: An event SHALL be detected in cycle N when match=1 and match_prev=0, including a match created by a threshold write.
- REQ-017: ts_r SHALL be a free-running counter, incrementing every cycle and wrapping from 2^ts_width_p-1 to 0.
- REQ-018: An event detected in cycle N SHALL enqueue the ts_r value of cycle N, with v_o=1 and that record visible at the head in cycle N+1.
- REQ-019: Events SHALL be buffered in a 2-entry FIFO in order.
- REQ-020: v_o SHALL be 1 exactly when the FIFO is non-empty.
- REQ-021: yumi_i dequeues the head; yumi_i=1 while v_o=0 is illegal and SHALL be flagged by a simulation assertion.
- REQ-022: Event with FIFO full and yumi_i=0: the event is dropped, FIFO contents unchanged.
- REQ-023: Event with FIFO full and yumi_i=1 in the same cycle: dequeue and enqueue both occur, and nothing is dropped.
- REQ-024: A sustained match SHALL produce exactly one event, with no re-trigger until match has been 0 for at least one cycle.

Reset
- REQ-025: On reset_i=1 the block SHALL clear thresh_r, ts_r, the FIFO (v_o=0) and dropped_o to 0, and set match_prev to 1.
- REQ-026: Because match_prev resets to 1, no event SHALL be produced in the first cycle after reset release when count_i=0 matches the reset threshold.
- REQ-027: Reset asserted mid-operation SHALL discard buffered events, and ts_o is don't-care while v_o=0.

Configuration
- REQ-028: With BSG_COUNT_MATCH_DROP_CNT_EN defined, dropped_o SHALL increment by 1 per dropped event and saturate at 15.
- REQ-029: With BSG_COUNT_MATCH_DROP_CNT_EN undefined, dropped_o SHALL be constant 0 and no counter logic is instantiated.

Structure
- REQ-030: Package bsg_count_match_pkg SHALL hold the event record typedef (timestamp field) and the dropped-counter width constant (4).
- REQ-031: The FIFO SHALL be an instance of bsg_two_fifo (ready/valid-in, valid/yumi-out); all other logic is local.

Verification
- REQ-032: Reset, thresh=0, count_i held 0 for 10 cycles -> v_o stays 0 and dropped_o=0.
- REQ-033: Write thresh=5, count_i ramps 0..10 with ts_r=12 in the match cycle -> exactly one record, ts_o=12, v_o=1 one cycle after the match; yumi -> v_o=0.
- REQ-034: Three matches with no yumi -> two records kept in order, dropped_o=1 with the macro and 0 without; fourth match with yumi same cycle -> no further drop.
- REQ-035: Write thresh=51 -> ignored; thresh_r keeps the prior value, so a match at the old value still fires.
- REQ-036: count_i held at thresh for 20 cycles -> exactly one event; ts_r wrap 255->0 across a match -> ts_o=0 recorded correctly.
- REQ-037: Reset asserted with 2 records buffered -> v_o=0 the next cycle and dropped_o=0.

Source files
------------

// File: rtl/bsg_count_match_pkg.sv
// Shared types and constants for bsg_count_match_event.
package bsg_count_match_pkg;

  localparam int unsigned DropCntWidth = 4;
  localparam int unsigned TsWidth      = 8;

  typedef struct packed {
    logic [TsWidth-1:0] ts;
  } event_rec_t;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, ready/valid on input and valid/yumi on output.
// ready_o stays high when full if the head is being taken in the same cycle.
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               rptr_q, wptr_q;
  logic [1:0]         cnt_q;
  logic               full, enq, deq;

  assign full    = (cnt_q == 2'd2);
  assign v_o     = (cnt_q != 2'd0);
  assign ready_o = ~full | yumi_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
      unique case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // When full with a dequeue, wptr equals rptr, so the departing head slot is reused.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_count_match_event.sv
// Timestamps rising edges of (count_i == threshold) into a 2-entry event FIFO.
// Define BSG_COUNT_MATCH_DROP_CNT_EN to enable the saturating dropped-event counter.
module bsg_count_match_event
  import bsg_count_match_pkg::*;
#(
  parameter int unsigned width_p    = 6,
  parameter int unsigned max_val_p  = 50,
  parameter int unsigned ts_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      count_i,
  input  logic                    thresh_set_i,
  input  logic [width_p-1:0]      thresh_i,
  output logic                    v_o,
  output logic [ts_width_p-1:0]   ts_o,
  input  logic                    yumi_i,
  output logic [DropCntWidth-1:0] dropped_o
);

  logic [width_p-1:0]    thresh_q;
  logic [ts_width_p-1:0] ts_q;
  logic                  match_prev_q;
  logic                  match, event_det, thresh_ok, fifo_ready;
  event_rec_t            rec_in, rec_out;

  assign match     = (count_i == thresh_q);
  assign event_det = match & ~match_prev_q;
  assign thresh_ok = thresh_set_i & (32'(thresh_i) <= max_val_p);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      thresh_q     <= '0;
      ts_q         <= '0;
      // Starting at 1 suppresses a spurious event from count 0 matching threshold 0.
      match_prev_q <= 1'b1;
    end else begin
      ts_q         <= ts_q + 1'b1;
      match_prev_q <= match;
      if (thresh_ok) thresh_q <= thresh_i;
    end
  end

  always_comb begin
    rec_in    = '0;
    rec_in.ts = TsWidth'(ts_q);
  end

  bsg_two_fifo #(
    .width_p($bits(event_rec_t))
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(fifo_ready),
    .v_i    (event_det),
    .data_i (rec_in),
    .v_o    (v_o),
    .data_o (rec_out),
    .yumi_i (yumi_i)
  );

  assign ts_o = ts_width_p'(rec_out.ts);

`ifdef BSG_COUNT_MATCH_DROP_CNT_EN
  logic                    drop;
  logic [DropCntWidth-1:0] dropped_q;

  assign drop = event_det & ~fifo_ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dropped_q <= '0;
    end else if (drop && (dropped_q != '1)) begin
      dropped_q <= dropped_q + 1'b1;
    end
  end

  assign dropped_o = dropped_q;
`else
  logic unused_fifo_ready;
  assign unused_fifo_ready = fifo_ready;
  assign dropped_o         = '0;
`endif

  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
